// File: rtl/sram_like_mem_slave.sv
// sram_like_mem_slave: SRAM-like responder with programmable accept/return latency and an
// in-order queue of outstanding transactions; memory is touched only when a response fires.
module sram_like_mem_slave #(
    parameter int MEM_AW      = 12,
    parameter int ADDR_LAT    = 0,
    parameter int DATA_LAT    = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);
    localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    logic [31:0]       mem [2**MEM_AW];
    logic [OUTSTANDING-1:0] q_vld;
    logic              q_wr    [OUTSTANDING];
    logic [1:0]        q_size  [OUTSTANDING];
    logic [MEM_AW+1:0] q_addr  [OUTSTANDING];
    logic [31:0]       q_wdata [OUTSTANDING];
    logic [3:0]        q_age   [OUTSTANDING];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [2:0]        wait_cnt;
    logic              full, push, pop;
    logic [MEM_AW-1:0] head_idx;
    logic [1:0]        head_size, head_lane;
    logic [3:0]        mask;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full         = count == CW'(OUTSTANDING);
        data_addr_ok = data_req & resetn & ~full & (wait_cnt == 3'(ADDR_LAT));
        push         = data_addr_ok;
        pop          = q_vld[rd_ptr] & (q_age[rd_ptr] == 4'(DATA_LAT));
        data_data_ok = pop;
        head_idx     = q_addr[rd_ptr][MEM_AW+1:2];
        head_size    = q_size[rd_ptr];
        head_lane    = q_addr[rd_ptr][1:0];
        data_rdata   = (pop & ~q_wr[rd_ptr]) ? mem[head_idx] : 32'h0;
        mask         = head_size[1] ? 4'hf :
                       head_size[0] ? (head_lane[1] ? 4'b1100 : 4'b0011) :
                       4'b0001 << head_lane;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_vld    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= (!data_req || push) ? 3'd0 :
                        (wait_cnt == 3'(ADDR_LAT)) ? wait_cnt : wait_cnt + 3'd1;
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= nxt(rd_ptr);
            end
            if (push) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= nxt(wr_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload and ages carry no reset: they are only meaningful while the slot is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < OUTSTANDING; i++)
            if (q_vld[i] && q_age[i] != 4'(DATA_LAT)) q_age[i] <= q_age[i] + 4'd1;
        if (push) begin
            q_wr[wr_ptr]    <= data_wr;
            q_size[wr_ptr]  <= data_size;
            q_addr[wr_ptr]  <= data_addr[MEM_AW+1:0];
            q_wdata[wr_ptr] <= data_wdata;
            q_age[wr_ptr]   <= 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (pop && q_wr[rd_ptr])
            for (int b = 0; b < 4; b++)
                if (mask[b]) mem[head_idx][8*b +: 8] <= q_wdata[rd_ptr][8*b +: 8];
    end
endmodule

// File: tb/tb_sram_like_mem_slave.sv
// tb_sram_like_mem_slave: directed checks of handshake timing, byte lanes, backpressure,
// address latency, reset flush and address aliasing.
module tb_sram_like_mem_slave;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        req = 1'b0, req1 = 1'b0, wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata, rdata1;
    logic        ak, dk, ak1, dk1;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    sram_like_mem_slave dut (
        .clk(clk), .resetn(resetn), .data_req(req), .data_wr(wr), .data_size(size),
        .data_addr(addr), .data_wdata(wdata), .data_rdata(rdata),
        .data_addr_ok(ak), .data_data_ok(dk)
    );

    sram_like_mem_slave #(.ADDR_LAT(3)) dut_lat (
        .clk(clk), .resetn(resetn), .data_req(req1), .data_wr(1'b0), .data_size(2'd2),
        .data_addr(addr), .data_wdata(wdata), .data_rdata(rdata1),
        .data_addr_ok(ak1), .data_data_ok(dk1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat,
                        output int acyc);
        bit seen;
        @(posedge clk); #1;
        req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
        acyc = 0;
        @(negedge clk);
        while (!ak && acyc < 20) begin
            acyc++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        req = 1'b0;
        lat = 99; rd = 'x; seen = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (dk) begin
                seen = 1; lat = k; rd = rdata;
            end
        end
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat, ac;
        xfer(1'b1, 2'd2, a, d, rd, lat, ac);
        chk("wr_lat", 32'(lat), 32'd2);
    endtask

    initial begin
        logic [31:0] rd;
        int lat, ac, idx, nd;
        logic [7:0] akv, dkv;
        bit seen;

        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ak", 32'(ak), 0);
        chk("rst_dk", 32'(dk), 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clk); #1;
        req = 1'b0; resetn = 1'b1;

        xfer(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, rd, lat, ac);
        chk("w_acc_cyc", 32'(ac), 0);
        chk("w_lat", 32'(lat), 2);
        chk("w_rdata", rd, 0);
        @(negedge clk);
        chk("idle_rdata", rdata, 0);
        chk("idle_dk", 32'(dk), 0);
        xfer(1'b0, 2'd2, 32'h100, 32'h0, rd, lat, ac);
        chk("r_acc_cyc", 32'(ac), 0);
        chk("r_lat", 32'(lat), 2);
        chk("r_data", rd, 32'hDEADBEEF);

        wr_word(32'h40, 32'h11223344);
        xfer(1'b1, 2'd0, 32'h43, 32'hAA000000, rd, lat, ac);
        xfer(1'b1, 2'd1, 32'h40, 32'h00005566, rd, lat, ac);
        xfer(1'b0, 2'd2, 32'h40, 32'h0, rd, lat, ac);
        chk("lanes", rd, 32'hAA225566);

        wr_word(32'h4008, 32'hCAFEF00D);
        xfer(1'b0, 2'd2, 32'h8, 32'h0, rd, lat, ac);
        chk("alias", rd, 32'hCAFEF00D);

        for (int i = 0; i < 4; i++) wr_word(32'h200 + 32'(4*i), 32'h10000000 + 32'(i));
        idx = 0; nd = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            req = idx < 4; wr = 1'b0; size = 2'd2; addr = 32'h200 + 32'(4*idx);
            @(negedge clk);
            akv[c] = ak; dkv[c] = dk;
            if (dk) begin
                chk("bp_rdata", rdata, 32'h10000000 + 32'(nd));
                nd++;
            end
            if (ak) idx++;
        end
        chk("bp_ak", 32'(akv), 32'h1B);
        chk("bp_dk", 32'(dkv), 32'h6C);
        chk("bp_count", 32'(nd), 4);

        addr = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            req1 = 1'b1;
            @(negedge clk);
            chk("alat_hold", 32'(ak1), 32'(c == 3));
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            req1 = c != 2;
            @(negedge clk);
            chk("alat_drop", 32'(ak1), 32'(c == 6));
        end
        @(posedge clk); #1;
        req1 = 1'b0;

        wr_word(32'h0, 32'h0);
        wr_word(32'h4, 32'h0);
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h0; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rf_acc0", 32'(ak), 1);
        @(posedge clk); #1;
        addr = 32'h4;
        @(negedge clk);
        chk("rf_acc1", 32'(ak), 1);
        @(posedge clk); #1;
        resetn = 1'b0; wr = 1'b0; addr = 32'h0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen |= dk;
            if (c == 0) chk("rf_ak_in_rst", 32'(ak), 0);
        end
        chk("rf_no_dk", 32'(seen), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rf_ak_after", 32'(ak), 1);
        @(posedge clk); #1;
        req = 1'b0;
        rd = 'x; seen = 0; lat = 99;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (dk) begin
                seen = 1; lat = k; rd = rdata;
            end
        end
        chk("rf_lat", 32'(lat), 2);
        chk("rf_rd0", rd, 0);
        xfer(1'b0, 2'd2, 32'h4, 32'h0, rd, lat, ac);
        chk("rf_rd4", rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_like_mem_slave.md
Name: sram_like_mem_slave

Overview:
- Responder end of the SRAM-like data interface (req/wr/size/addr/wdata in; rdata/addr_ok/data_ok out) that the data cache drives as initiator.
- Word-organised on-chip memory model with programmable address-accept and data-return latency.
- Supports a bounded number of in-order outstanding transactions.
- Used as the memory behind d_cache in unit benches and as a fast scratch memory in SoC builds.

Parameters:
- MEM_AW, 12, log2 of memory depth in 32-bit words (word index = data_addr[MEM_AW+1:2]; higher address bits ignored, aliasing).
- ADDR_LAT, 0, wait cycles a continuously held req spends before data_addr_ok may assert (0 to 7).
- DATA_LAT, 2, cycles from the accept edge to the earliest data_ok for that transaction (1 to 15).
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1 to 4).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- data_req  input  1  initiator request valid.
- data_wr  input  1  1 = write, 0 = read.
- data_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- data_addr  input  32  byte address.
- data_wdata  input  32  write data, lane-aligned as on the bus.
- data_rdata  output  32  read data; valid only while data_ok=1, otherwise 0.
- data_addr_ok  output  1  request accepted this cycle.
- data_data_ok  output  1  one-cycle response pulse, one per accepted transaction.

Behaviour:
- Accept handshake
  - A transaction is accepted on a rising edge where data_req=1 and data_addr_ok=1.
  - data_addr_ok = data_req & resetn & ~full & (wait_cnt == ADDR_LAT).
  - The accept path is combinational from data_req; no registered bubble.
- wait_cnt
  - Counts cycles with data_req=1 and no accept, saturating at ADDR_LAT.
  - Clears on accept or when data_req=0, so a dropped request restarts the wait.
- Queue
  - In-order FIFO of OUTSTANDING entries: {wr, size, addr[MEM_AW+1:0], wdata, age[3:0]}.
  - On enqueue, age is set to 1.
  - Every valid entry's age increments each cycle, saturating at DATA_LAT.
- full
  - full = (count == OUTSTANDING), evaluated before any same-cycle pop.
  - There is no pop-to-push bypass: a full queue blocks addr_ok even in a cycle where data_ok fires.
- Response
  - data_data_ok = head valid & (head.age == DATA_LAT).
  - The head is popped on that edge, so responses can be back-to-back on consecutive cycles.
  - Minimum accept-to-data_ok latency is DATA_LAT cycles; with DATA_LAT=1, data_ok comes the cycle after addr_ok and never in the same cycle.
- Memory side effect at response time (keeps ordering exact)
  - Read: data_rdata = mem[head word index], the full 32-bit word regardless of size; the core extracts lanes.
  - Write: on the data_ok edge, the byte lanes selected by the mask are updated; data_rdata reads 0.
- Write byte mask
  - size 00: one-hot on addr[1:0] (00→0001, 01→0010, 10→0100, 11→1000).
  - size 01: addr[1] ? 1100 : 0011 (addr[0] ignored).
  - size 10/11: 1111 (addr[1:0] ignored).
- Simultaneous push and pop: count unchanged; the new entry goes to the tail with age 1.
- Pointers: rd/wr pointers wrap modulo OUTSTANDING; count is kept explicitly, giving full/empty without ambiguity.
- Reset (async assert, sync-safe deassert)
  - FIFO emptied, count=0, wait_cnt=0.
  - data_addr_ok=0, data_data_ok=0, data_rdata=0.
  - In-flight transactions are discarded with no data_ok and no memory write.
  - Memory array contents are not reset.
- Initiator obligation (not checked): request fields stay stable while req=1 until addr_ok.

Test Plan:
- Reset defaults: ADDR_LAT=0, DATA_LAT=2. Word write 0xDEADBEEF @0x100 (addr_ok in cycle 0), then word read @0x100 → data_ok at cycle 2 for each; read returns 0xDEADBEEF; rdata=0 outside data_ok.
- Byte lanes: word write 0x11223344 @0x40, then sb 0xAA @0x43 (wdata 0xAA000000), then sh 0x5566 @0x40 (wdata 0x00005566) → read @0x40 returns 0xAA225566.
- Backpressure: OUTSTANDING=2, req held for 4 back-to-back reads → addr_ok on cycles 0 and 1, low on cycle 2 even though data_ok fires there, then accepts resume. Exactly 4 data_ok pulses, in order.
- Address latency: ADDR_LAT=3 → addr_ok first in the 4th cycle of held req. Dropping req after 2 cycles and reasserting → the wait restarts; 3 more wait cycles before accept.
- Reset mid-flight: accept 2 writes @0x0 and @0x4 (old values 0x0), pull resetn low before either data_ok → no data_ok; after release, reads of @0x0 and @0x4 return 0x0; addr_ok is available immediately.
- Aliasing: MEM_AW=12, write 0xCAFEF00D @0x0000_4008 → read @0x0000_0008 returns 0xCAFEF00D.
